// File: rtl/seq_bam_mul_ctrl.sv
// Iterative broken-array (BAM) multiplier: one partial-product row per cycle through a shared masked adder.
// Optional early termination on exhausted multiplier bits is enabled by defining BAM_ZERO_SKIP_EN.
module seq_bam_mul_ctrl #(
  parameter int WIDTH = 8,
  parameter int CFG_W = $clog2(2*WIDTH)+1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [CFG_W-1:0]     cfg_h,
  input  logic [CFG_W-1:0]     cfg_v,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 busy
);

  localparam int RW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     b_r;
  logic [CFG_W-1:0]     v_r;
  logic [RW-1:0]        row;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   pp;
  logic [CFG_W-1:0]     h_eff;
  logic                 idle_done;
  logic                 last_row;

  // Break levels above WIDTH drop every row, same as WIDTH itself.
  assign h_eff = (cfg_h > CFG_W'(WIDTH)) ? CFG_W'(WIDTH) : cfg_h;
  assign out_p = acc;

`ifdef BAM_ZERO_SKIP_EN
  assign idle_done = (h_eff >= CFG_W'(WIDTH)) || ((in_b >> h_eff) == '0);
  assign last_row  = (row == RW'(WIDTH-1)) || (((b_r >> row) >> 1) == '0) || (a_r == '0);
`else
  assign idle_done = (h_eff >= CFG_W'(WIDTH));
  assign last_row  = (row == RW'(WIDTH-1));
`endif

  // Current row's multiplicand with columns below the vertical break masked off.
  always_comb begin
    pp = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (a_r[i] && ((i + int'(row)) >= int'(v_r))) pp[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      acc       <= '0;
      row       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      v_r       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= in_a;
            b_r      <= in_b;
            v_r      <= cfg_v;
            acc      <= '0;
            row      <= h_eff[RW-1:0];
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= idle_done ? DONE : RUN;
          end
        end
        RUN: begin
          if (b_r[row]) acc <= acc + (pp << row);
          row <= row + RW'(1);
          if (last_row) state <= DONE;
        end
        DONE: begin
          // out_valid rises one cycle after entering DONE; the handoff cycle never accepts.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bam_mul_ctrl.sv
// Self-checking bench for seq_bam_mul_ctrl: directed literal cases plus randomized operations
// checked every cycle against a sum-of-partial-products model with handshake timing.
module tb_seq_bam_mul_ctrl;

  localparam int W  = 8;
  localparam int CW = $clog2(2*W)+1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    in_a = '0;
  logic [W-1:0]    in_b = '0;
  logic [CW-1:0]   cfg_h = '0;
  logic [CW-1:0]   cfg_v = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [2*W-1:0]  out_p;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  seq_bam_mul_ctrl #(.WIDTH(W), .CFG_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .cfg_h(cfg_h), .cfg_v(cfg_v),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .busy(busy)
  );

  always #5 clk = ~clk;

  // Exact sum of the kept partial products.
  function automatic logic [2*W-1:0] golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input int h, input int v);
    int s;
    s = 0;
    for (int j = 0; j < W; j++)
      for (int i = 0; i < W; i++)
        if (j >= h && i + j >= v && a[i] && b[j]) s += (1 << (i + j));
    return s[2*W-1:0];
  endfunction

  // Cycles from the accepting edge until out_valid is seen.
  function automatic int latency(input logic [W-1:0] a, input logic [W-1:0] b, input int h);
    int he;
    int top;
    he = (h > W) ? W : h;
    if (he >= W) return 1;
`ifdef BAM_ZERO_SKIP_EN
    if ((b >> he) == 0) return 1;
    if (a == 0) return 2;
    top = 0;
    for (int j = 0; j < W; j++) if (b[j]) top = j;
    return top - he + 2;
`else
    top = 0;
    return W - he + 1 + top;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: 0 idle, 1 computing, 2 result presented.
  int              m_state = 0;
  int              m_count = 0;
  logic [2*W-1:0]  m_p = '0;
  bit              check_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_state  = 0;
      check_en = 1'b1;
    end else if (m_state == 0) begin
      if (in_valid) begin
        m_p     = golden(in_a, in_b, int'(cfg_h), int'(cfg_v));
        m_count = latency(in_a, in_b, int'(cfg_h));
        m_state = 1;
      end
    end else if (m_state == 1) begin
      m_count--;
      if (m_count == 0) m_state = 2;
    end else begin
      if (out_ready) m_state = 0;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("in_ready", {31'd0, in_ready}, {31'd0, m_state == 0});
      checkOutput("busy", {31'd0, busy}, {31'd0, m_state != 0});
      checkOutput("out_valid", {31'd0, out_valid}, {31'd0, m_state == 2});
      if (m_state == 2) checkOutput("out_p", {16'd0, out_p}, {16'd0, m_p});
    end
  end

  // Issue one operation from an idle DUT and wait for the result; called at posedge+#1.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [CW-1:0] h, input logic [CW-1:0] v, input bit noisy,
                               output logic [2*W-1:0] p, output int lat);
    in_a = a; in_b = b; cfg_h = h; cfg_v = v; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    p = '0;
    for (int k = 1; k <= 40; k++) begin
      if (noisy) begin
        in_valid = 1'($urandom_range(0, 1));
        in_a = W'($urandom); in_b = W'($urandom);
        cfg_h = CW'($urandom); cfg_v = CW'($urandom);
      end
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k;
        p = out_p;
        break;
      end
    end
    in_valid = 1'b0;
    if (lat < 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL timeout: out_valid never rose, required within 40 cycles");
    end
  endtask

  task automatic takeResult(input int hold);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [2*W-1:0] p;
    int lat;
    logic [W-1:0] ra, rb;
    logic [CW-1:0] rh, rv;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_out_p", {16'd0, out_p}, 32'd0);

    applyStimulus(8'hFF, 8'hFF, 5'd0, 5'd0, 1'b0, p, lat);
    checkOutput("t1_p", {16'd0, p}, 32'hFE01);
    checkOutput("t1_lat", lat, 32'd9);
    takeResult(0);

    applyStimulus(8'hFF, 8'hFF, 5'd4, 5'd12, 1'b0, p, lat);
    checkOutput("t2_p", {16'd0, p}, 32'hB000);
    checkOutput("t2_lat", lat, 32'd5);
    takeResult(0);

    applyStimulus(8'h7F, 8'h0F, 5'd4, 5'd12, 1'b0, p, lat);
    checkOutput("t3b_p", {16'd0, p}, 32'h0000);
    takeResult(1);

    applyStimulus(8'hA5, 8'h3C, 5'd8, 5'd0, 1'b0, p, lat);
    checkOutput("t4_h8_p", {16'd0, p}, 32'h0000);
    checkOutput("t4_h8_lat", lat, 32'd1);
    takeResult(0);

    applyStimulus(8'hFF, 8'hFF, 5'd0, 5'd16, 1'b0, p, lat);
    checkOutput("t4_v16_p", {16'd0, p}, 32'h0000);
    checkOutput("t4_v16_lat", lat, 32'd9);
    takeResult(0);

    applyStimulus(8'h80, 8'h20, 5'd4, 5'd12, 1'b0, p, lat);
    checkOutput("t3a_p", {16'd0, p}, 32'h1000);
    repeat (10) begin
      @(posedge clk); #1;
    end
    checkOutput("t5_hold_p", {16'd0, out_p}, 32'h1000);
    checkOutput("t5_hold_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("t5_hold_valid", {31'd0, out_valid}, 32'd1);
    takeResult(0);
    checkOutput("t5_after_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("t5_after_valid", {31'd0, out_valid}, 32'd0);

    in_a = 8'hFF; in_b = 8'hFF; cfg_h = 5'd0; cfg_v = 5'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("t6_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("t6_out_p", {16'd0, out_p}, 32'd0);
    checkOutput("t6_in_ready", {31'd0, in_ready}, 32'd1);
    applyStimulus(8'hFF, 8'h81, 5'd1, 5'd3, 1'b0, p, lat);
    checkOutput("t6_next_p", {16'd0, p}, 32'h7F80);
    takeResult(0);

    applyStimulus(8'h03, 8'h01, 5'd0, 5'd0, 1'b0, p, lat);
    checkOutput("t7_p", {16'd0, p}, 32'h0003);
`ifdef BAM_ZERO_SKIP_EN
    checkOutput("t7_lat", lat, 32'd2);
`else
    checkOutput("t7_lat", lat, 32'd9);
`endif
    takeResult(0);

    for (int n = 0; n < 3000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (n % 16 == 0) ra = '0;
      if (n % 16 == 1) rb = W'(1) << $urandom_range(0, W-1);
      rh = CW'($urandom_range(0, 10));
      rv = CW'($urandom_range(0, 31));
      applyStimulus(ra, rb, rh, rv, 1'b1, p, lat);
      checkOutput("rand_p", {16'd0, p}, {16'd0, golden(ra, rb, int'(rh), int'(rv))});
      checkOutput("rand_lat", lat, latency(ra, rb, int'(rh)));
      takeResult($urandom_range(0, 2));
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
